hazard_scheduler: RTL
=====================

# hazard_scheduler

In-order issue controller for the five-stage scalar/vector pipeline. The pipeline has no forwarding, so this block keeps a per-register pending-write scoreboard for both register banks and stalls Decode on RAW hazards until the producing instruction has written back. It also squashes wrong-path instructions after a taken branch in Execute. It drives the stall/flush controls of the Fetch, Fetch→Decode and Decode→Execute registers, and exposes stall/flush performance counters.

## Interface
- REG_ADDRESS_WIDTH, 4: register address width.
- REGNUM, 16: registers per bank (scalar and vector banks are equal size).
- FLUSH_CYCLES, 1: extra Decode-flush cycles after the branch cycle; covers instruction-memory read latency.
- COUNT_WIDTH, 16: performance counter width.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low (0 = reset).
- validD  in  1  Decode holds a real instruction.
- useReg1D, useReg2D  in  1  instruction reads source 1 / source 2.
- reg1IsVectorD, reg2IsVectorD  in  1  source bank select (1 = vector).
- reg1AddressD, reg2AddressD  in  REG_ADDRESS_WIDTH  source addresses.
- destAddressD  in  REG_ADDRESS_WIDTH  destination address.
- writeEnableScalarD, writeEnableVectorD  in  1  instruction writes the scalar / vector destination.
- takeBranchE  in  1  branch in Execute is taken this cycle.
- writeEnableScalarWB, writeEnableVectorWB  in  1  writeback strobes.
- writeAddressWB  in  REG_ADDRESS_WIDTH  writeback address.
- stallF, stallD  out  1  hold the PC / hold the Fetch→Decode register.
- flushD, flushE  out  1  bubble into the Fetch→Decode / Decode→Execute register.
- pendingScalar, pendingVector  out  REGNUM  scoreboard bits.
- state  out  2  RUN=0, STALL=1, FLUSH=2.
- stallCount, flushCount  out  COUNT_WIDTH  saturating event counters.

## Operation
- **Hazard test (combinational):**
  - hazard = validD and ((useReg1D and pending[reg1IsVectorD][reg1AddressD]) or (useReg2D and pending[reg2IsVectorD][reg2AddressD])).
  - The pending bank for the destination is tested the same way when the instruction writes it (WAW check).
- **Priority:** flush > stall > issue.
  - takeBranchE=1: flushD=flushE=1, stallF=stallD=0, no issue this cycle.
  - Otherwise, hazard=1: stallF=stallD=1 and flushE=1 (a bubble goes to Execute).
  - Otherwise, when state is FLUSH: flushD=1 only.
- **Issue:** validD, no hazard, no flush, state≠FLUSH. On issue, the edge sets pending[bank][destAddressD] for each destination write enable that is asserted.
- **Clear:** a writeback strobe clears pending[bank][writeAddressWB] at the edge. If an issue and a clear hit the same bit in the same cycle, set wins.
- **Same-cycle writeback:** a clear does not unblock Decode in the same cycle. The hazard is evaluated on registered bits, so the stall releases one cycle after writeback. This matches the register file writing at the edge.
- **FSM:**
  - RUN→STALL on hazard. STALL→RUN when the hazard clears.
  - Any state→FLUSH on takeBranchE; the flush counter loads FLUSH_CYCLES.
  - FLUSH decrements the counter each cycle and returns to RUN after FLUSH_CYCLES cycles. A new takeBranchE during FLUSH reloads the counter.
  - With FLUSH_CYCLES=0, the FSM returns to RUN directly from the branch cycle.
- **Counters:**
  - stallCount +1 each cycle with stallD=1.
  - flushCount +1 on each takeBranchE.
  - Both saturate at all-ones and never wrap.
- **Reset:** while reset=0 at an edge, every output register is cleared: pending bits 0, counters 0, state RUN. All combinational outputs are then 0 given validD=0 and takeBranchE=0. Reset takes effect mid-stall and mid-flush with no residual state.

## Timing
- Stall/flush outputs are combinational from the current inputs and registered state, and are valid in the same cycle.
- Scoreboard, FSM and counters update on the rising clock edge.
- RAW penalty: a consumer directly behind its producer stalls 3 cycles (producer in E, M, WB), then issues on the 4th cycle.
- Branch penalty: 1 + FLUSH_CYCLES squashed Decode slots.

## Test plan
- **Reset:** reset=0 for 2 cycles with random inputs → all outputs 0, state=RUN.
- **RAW scalar:**
  - Stimulus: issue write S3, then next cycle reader of S3; WB strobe for S3 arrives 3 cycles after the producer issue.
  - Required: stallD=1 for exactly 3 cycles, stallCount=3, pendingScalar[3] 1→0.
- **Bank separation:** pending V3 with a reader of scalar S3 → no stall. Reader of V3 → stall.
- **Set/clear collision:** WB clears S5 while a new writer of S5 issues the same cycle → pendingScalar[5]=1 afterwards.
- **Branch over a stall:** hazard active and takeBranchE=1 → flushD=flushE=1, stallD=0, no pending set; FLUSH lasts 1 cycle (flushD=1); flushCount=1.
- **Saturation:** COUNT_WIDTH=4 with 20 stall cycles → stallCount=15.

Source files
------------

// File: rtl/hazard_scheduler_if.sv
// hazard_scheduler_if: Decode/Execute/Writeback hazard bus between the pipeline and the issue controller
interface hazard_scheduler_if #(
   parameter int REG_ADDRESS_WIDTH = 4,
   parameter int REGNUM = 16,
   parameter int COUNT_WIDTH = 16
);
   logic validD, useReg1D, useReg2D, reg1IsVectorD, reg2IsVectorD;
   logic [REG_ADDRESS_WIDTH-1:0] reg1AddressD, reg2AddressD, destAddressD, writeAddressWB;
   logic writeEnableScalarD, writeEnableVectorD, takeBranchE;
   logic writeEnableScalarWB, writeEnableVectorWB;
   logic stallF, stallD, flushD, flushE;
   logic [REGNUM-1:0] pendingScalar, pendingVector;
   logic [1:0] state;
   logic [COUNT_WIDTH-1:0] stallCount, flushCount;
   modport slave (
      input validD, useReg1D, useReg2D, reg1IsVectorD, reg2IsVectorD,
      input reg1AddressD, reg2AddressD, destAddressD, writeAddressWB,
      input writeEnableScalarD, writeEnableVectorD, takeBranchE,
      input writeEnableScalarWB, writeEnableVectorWB,
      output stallF, stallD, flushD, flushE,
      output pendingScalar, pendingVector, state, stallCount, flushCount
   );
   modport master (
      output validD, useReg1D, useReg2D, reg1IsVectorD, reg2IsVectorD,
      output reg1AddressD, reg2AddressD, destAddressD, writeAddressWB,
      output writeEnableScalarD, writeEnableVectorD, takeBranchE,
      output writeEnableScalarWB, writeEnableVectorWB,
      input stallF, stallD, flushD, flushE,
      input pendingScalar, pendingVector, state, stallCount, flushCount
   );
endinterface

// File: rtl/hazard_scheduler.sv
// hazard_scheduler: in-order issue control with per-register pending-write scoreboard and branch squash
module hazard_scheduler #(
   parameter int REG_ADDRESS_WIDTH = 4,
   parameter int REGNUM = 16,
   parameter int FLUSH_CYCLES = 1,
   parameter int COUNT_WIDTH = 16
) (
   input logic clock,
   input logic reset,
   hazard_scheduler_if.slave bus
);
   localparam int FCW = FLUSH_CYCLES > 0 ? $clog2(FLUSH_CYCLES + 1) : 1;
   localparam logic [REGNUM-1:0] ONE = {{(REGNUM-1){1'b0}}, 1'b1};
   typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, FLUSH = 2'd2} stateT;
   stateT stateQ, stateN;
   logic [FCW-1:0] flushLeftQ, flushLeftN;
   logic [REGNUM-1:0] pendS, pendV, setS, setV, clrS, clrV;
   logic [COUNT_WIDTH-1:0] stallCnt, flushCnt;
   logic raw1, raw2, waw, hazard, issue;
   // hazard looks only at registered bits, so a same-cycle writeback cannot release the stall
   assign raw1 = bus.useReg1D && (bus.reg1IsVectorD ? pendV[bus.reg1AddressD] : pendS[bus.reg1AddressD]);
   assign raw2 = bus.useReg2D && (bus.reg2IsVectorD ? pendV[bus.reg2AddressD] : pendS[bus.reg2AddressD]);
   assign waw = (bus.writeEnableScalarD && pendS[bus.destAddressD]) ||
                (bus.writeEnableVectorD && pendV[bus.destAddressD]);
   assign hazard = bus.validD && (raw1 || raw2 || waw);
   assign issue = bus.validD && !hazard && !bus.takeBranchE && stateQ != FLUSH;
   assign setS = issue && bus.writeEnableScalarD ? ONE << bus.destAddressD : '0;
   assign setV = issue && bus.writeEnableVectorD ? ONE << bus.destAddressD : '0;
   assign clrS = bus.writeEnableScalarWB ? ONE << bus.writeAddressWB : '0;
   assign clrV = bus.writeEnableVectorWB ? ONE << bus.writeAddressWB : '0;
   always_comb begin
      stateN = stateQ;
      flushLeftN = flushLeftQ;
      bus.stallF = 1'b0;
      bus.stallD = 1'b0;
      bus.flushD = 1'b0;
      bus.flushE = 1'b0;
      if (bus.takeBranchE) begin
         bus.flushD = 1'b1;
         bus.flushE = 1'b1;
         stateN = FLUSH_CYCLES == 0 ? RUN : FLUSH;
         flushLeftN = FCW'(FLUSH_CYCLES);
      end else begin
         bus.stallF = hazard;
         bus.stallD = hazard;
         bus.flushE = hazard;
         bus.flushD = !hazard && stateQ == FLUSH;
         if (stateQ == FLUSH) begin
            flushLeftN = flushLeftQ - FCW'(1);
            stateN = flushLeftQ == FCW'(1) ? RUN : FLUSH;
         end else begin
            stateN = hazard ? STALL : RUN;
         end
      end
   end
   always_ff @(posedge clock) begin
      if (!reset) begin
         stateQ <= RUN;
         flushLeftQ <= '0;
         pendS <= '0;
         pendV <= '0;
         stallCnt <= '0;
         flushCnt <= '0;
      end else begin
         stateQ <= stateN;
         flushLeftQ <= flushLeftN;
         pendS <= (pendS & ~clrS) | setS;
         pendV <= (pendV & ~clrV) | setV;
         stallCnt <= stallCnt + COUNT_WIDTH'(bus.stallD && !(&stallCnt));
         flushCnt <= flushCnt + COUNT_WIDTH'(bus.takeBranchE && !(&flushCnt));
      end
   end
   assign bus.pendingScalar = pendS;
   assign bus.pendingVector = pendV;
   assign bus.state = stateQ;
   assign bus.stallCount = stallCnt;
   assign bus.flushCount = flushCnt;
endmodule
